// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared types and widths for the GCD request/response streams.
//   gcd_req_t  : request message {a, b}, a in the upper half
//   gcd_resp_t : response message (gcd result)
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_REQ_NBITS  = 32;
    localparam int GCD_RESP_NBITS = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } gcd_req_t;

    typedef logic [GCD_RESP_NBITS-1:0] gcd_resp_t;

endpackage

// File: rtl/gcd_tag_fifo.sv
// -----------------------------------------------------------------------------
// gcd_tag_fifo
// Small FIFO holding the requester index of every request forwarded to the
// GCD unit, so responses can be routed back in issue order.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : tag to store
//   pop        : discard the head entry (ignored when empty)
//   head       : oldest stored tag (meaningless when empty)
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module gcd_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_req_arbiter
// Shares one GCD unit between p_num_reqs requester streams. A round-robin
// arbiter forwards one {a,b} request per transfer; a tag FIFO remembers the
// requester of each outstanding request so responses return to their owner
// in issue order.
//   clk, rst              : clock, asynchronous active-high reset
//   req_val/req_rdy/msg   : per-requester request streams (msg slice i at
//                           [i*p_req_nbits +: p_req_nbits])
//   resp_val/resp_rdy/msg : per-requester response streams (same slicing)
//   gcd_req_*             : request stream to the GCD unit
//   gcd_resp_*            : response stream from the GCD unit
// -----------------------------------------------------------------------------
module gcd_req_arbiter
    import gcd_pkg::*;
#(
    parameter int p_num_reqs     = 4,
    parameter int p_max_inflight = 2,
    parameter int p_req_nbits    = GCD_REQ_NBITS,
    parameter int p_resp_nbits   = GCD_RESP_NBITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [p_num_reqs-1:0]            req_val,
    output logic [p_num_reqs-1:0]            req_rdy,
    input  logic [p_num_reqs*p_req_nbits-1:0]  req_msg,
    output logic [p_num_reqs-1:0]            resp_val,
    input  logic [p_num_reqs-1:0]            resp_rdy,
    output logic [p_num_reqs*p_resp_nbits-1:0] resp_msg,
    output logic                             gcd_req_val,
    input  logic                             gcd_req_rdy,
    output logic [p_req_nbits-1:0]           gcd_req_msg,
    input  logic                             gcd_resp_val,
    output logic                             gcd_resp_rdy,
    input  logic [p_resp_nbits-1:0]          gcd_resp_msg
);

    localparam int ID_W = $clog2(p_num_reqs);

    logic [ID_W-1:0] prio;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] head;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] cand;
    logic            any_val;
    logic            fifo_full;
    logic            fifo_empty;
    logic            issue_fire;
    logic            ret_fire;

    // Round-robin search starting at prio. Scanning from the farthest
    // candidate back to prio lets the nearest requesting index win last.
    always_comb begin
        winner   = prio;
        scan_sum = '0;
        cand     = '0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            scan_sum = {1'b0, prio} + (ID_W + 1)'(k);
            if (scan_sum >= (ID_W + 1)'(p_num_reqs)) begin
                scan_sum = scan_sum - (ID_W + 1)'(p_num_reqs);
            end
            cand = scan_sum[ID_W-1:0];
            if (req_val[cand]) begin
                winner = cand;
            end
        end
    end

    assign any_val = |req_val;

    // Request side is gated by rst so nothing looks acceptable while the
    // block is held in reset, even though the FIFO reads as empty then.
    // Full blocks issue regardless of a same-cycle pop: keeps resp_rdy off
    // the req_rdy path.
    assign gcd_req_val = ~rst & any_val & ~fifo_full;
    assign gcd_req_msg = gcd_req_val ? req_msg[winner*p_req_nbits +: p_req_nbits]
                                     : '0;

    always_comb begin
        req_rdy = '0;
        if (~rst && any_val && gcd_req_rdy && ~fifo_full) begin
            req_rdy[winner] = 1'b1;
        end
    end

    assign issue_fire = gcd_req_val & gcd_req_rdy;

    always_comb begin
        resp_val = '0;
        if (~fifo_empty) begin
            resp_val[head] = gcd_resp_val;
        end
    end

    assign gcd_resp_rdy = ~fifo_empty & resp_rdy[head];
    assign ret_fire     = gcd_resp_val & gcd_resp_rdy;
    assign resp_msg     = {p_num_reqs{gcd_resp_msg}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= '0;
        end else if (issue_fire) begin
            prio <= (winner == ID_W'(p_num_reqs - 1)) ? '0 : winner + 1'b1;
        end
    end

    gcd_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (p_max_inflight)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_fire),
        .push_data (winner),
        .pop       (ret_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifndef SYNTHESIS
    // A response with no outstanding tag has no owner to route to.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (rst)
        gcd_resp_val |-> ~fifo_empty)
        else $error("gcd response arrived with no outstanding request");
`endif

endmodule

// File: doc/gcd_req_arbiter.md
Name: gcd_req_arbiter

Overview:
Shares one GCD unit between p_num_reqs independent requester streams. Round-robin arbitration selects one requester's {a,b} message per transfer and forwards it to the GCD unit's request stream. A tag FIFO records the requester index of each forwarded message, so every GCD response is routed back to its originating requester in issue order. The block sits between the per-client val/rdy request/response stream ports and a single GCD unit instance.

Parameters:
p_num_reqs, 4, number of requesters (>=2); index width ID_W = $clog2(p_num_reqs)
p_max_inflight, 2, tag FIFO depth = max GCD transactions outstanding (>=1)
p_req_nbits, 32, request message width: {a[31:16], b[15:0]}
p_resp_nbits, 16, response message width (gcd result)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
req_val  in  p_num_reqs  per-requester request valid
req_rdy  out  p_num_reqs  per-requester request ready
req_msg  in  p_num_reqs*p_req_nbits  requester i message in bits [i*p_req_nbits +: p_req_nbits]
resp_val  out  p_num_reqs  per-requester response valid
resp_rdy  in  p_num_reqs  per-requester response ready
resp_msg  out  p_num_reqs*p_resp_nbits  response data, same slicing as req_msg
gcd_req_val  out  1  to GCD unit istream val
gcd_req_rdy  in  1  from GCD unit istream rdy
gcd_req_msg  out  p_req_nbits  to GCD unit istream msg
gcd_resp_val  in  1  from GCD unit ostream val
gcd_resp_rdy  out  1  to GCD unit ostream rdy
gcd_resp_msg  in  p_resp_nbits  from GCD unit ostream msg

Behaviour:
- State: round-robin pointer prio (ID_W bits), tag FIFO (p_max_inflight entries x ID_W), count of occupied entries.
- Reset (async, asserted): prio=0, FIFO empty, count=0. All outputs are combinational from this state, so during reset req_rdy=0, gcd_req_val=0, resp_val=0, gcd_resp_rdy=0.
- Arbitration (combinational, zero latency): winner = first i with req_val[i]=1, scanning prio, prio+1, ... with wrap at p_num_reqs-1 -> 0.
- gcd_req_val = any(req_val) & !fifo_full; gcd_req_msg = req_msg[winner]. The message is 0 when gcd_req_val=0.
- req_rdy[winner] = gcd_req_rdy & !fifo_full; all other req_rdy bits = 0. There is no val->rdy dependence on the GCD side.
- Issue fires when gcd_req_val & gcd_req_rdy. On fire: push winner into the FIFO; prio <= winner+1 (wrap). With no fire, prio holds.
- Response routing: head = FIFO head tag. When FIFO is non-empty, resp_val[head] = gcd_resp_val, and all other bits are 0.
- gcd_resp_rdy = !fifo_empty & resp_rdy[head].
- resp_msg: every slice is driven with gcd_resp_msg. Only the resp_val bit qualifies which slice is meaningful.
- Return fires when gcd_resp_val & gcd_resp_rdy; it pops the FIFO.
- Empty FIFO: gcd_resp_rdy=0. A response arriving with no outstanding tag is a protocol error (assertion in simulation only).
- Full FIFO (count==p_max_inflight): no issue. A pop in the same cycle does NOT unblock issue that cycle; this avoids a rdy->rdy combinational path.
- Simultaneous issue and return on a non-full FIFO: push and pop in the same cycle, count unchanged.
- A single requester is never starved: with all req_val=1 and free slots, grants rotate 0,1,2,3,0,...
- Responses to each requester arrive in that requester's issue order. Across requesters, order follows global issue order.
- A stalled resp_rdy on the head requester back-pressures the GCD unit and therefore all requesters (head-of-line blocking, accepted).
- Reset mid-operation: all tags are discarded. The GCD unit shares rst, so no stale response survives.
- Requester contract: req_msg[i] is held stable while req_val[i]=1 and not accepted.

Decomposition:
- Shared package gcd_pkg: typedef gcd_req_t (struct {a[15:0], b[15:0]}), gcd_resp_t (logic[15:0]), and constants GCD_REQ_NBITS=32 and GCD_RESP_NBITS=16.
- One natural sub-module: gcd_tag_fifo (parameterised width/depth; push/pop/full/empty, async reset). It holds the tag storage.
- The round-robin priority encoder stays inline.

Test Plan:
- Single requester 2 sends {15,5} -> gcd_req_msg=0x000F0005 same cycle; resp_val[2] with 5; no other resp_val bit is ever set.
- All 4 requesters val=1 continuously, msgs {3,9},{27,15},{21,49},{40,40} -> grant order 0,1,2,3 and responses 3@0, 3@1, 7@2, 40@3 in that order.
- GCD rdy held 0 for 5 cycles -> no issue, prio unchanged; release -> requester at prio issues first.
- p_max_inflight=2, resp_rdy of head requester held 0 -> after 2 issues gcd_req_val=0 and req_rdy all 0; raising resp_rdy drains the FIFO and issue resumes only on the cycle after the pop.
- Random delays (0-3 cycles) on each requester/consumer, 20 random {a,b} per requester -> each requester receives the reference-model gcd values in its own send order.
- Assert rst while 2 transactions are in flight -> outputs drop to reset values immediately (async); after release, a new {25,30} from requester 1 returns 5 to requester 1 only.
